// File: rtl/counter_ctrl_pkg.sv
// Shared types and function-select codes for the counter command front end.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2,
    RELEASE   = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] S_NOP  = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_UP   = 2'b10;
  localparam logic [1:0] S_DOWN = 2'b11;

endpackage

// File: rtl/counter_cmd_ctrl_btn_debounce.sv
// One raw button: 2-flop synchronizer, stable-count debounce, debounced level
// and a registered one-cycle rise flag.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lvl_q;
  logic             lvl_dly_q;
  logic             rise_q;

  // Rise flag is taken from the registered level, so it trails the level by a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      lvl_dly_q <= lvl_q;
      rise_q    <= lvl_q & ~lvl_dly_q;
      if (sync2_q != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          lvl_q <= ~lvl_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/counter_cmd_ctrl_sva.sv
// Protocol checks on the command outputs of counter_cmd_ctrl.
module counter_cmd_ctrl_sva #(
  parameter int REPEAT_RATE = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  input logic       en_i,
  input logic [1:0] s_i
);

  a_rate_min: assert property (@(posedge clk_i) REPEAT_RATE >= 2)
    else $error("REPEAT_RATE must be at least 2");

  a_no_back_to_back: assert property (@(posedge clk_i) disable iff (rst_i) en_i |=> !en_i)
    else $error("EN high in consecutive cycles");

  a_nop_when_idle: assert property (@(posedge clk_i) disable iff (rst_i) !en_i |-> (s_i == 2'b00))
    else $error("S not NOP while EN low");

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command front end: debounces up/down/load buttons and issues single-cycle
// EN/S/D commands to the 4-bit counter, with auto-repeat for up/down.
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int W            = 4,
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BTN_UP,
  input  logic         BTN_DN,
  input  logic         BTN_LD,
  input  logic [W-1:0] SW,
  output logic         EN,
  output logic [1:0]   S,
  output logic [W-1:0] D
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LD  = RPT_W'(REPEAT_RATE - 1);

  logic up_lvl, up_rise, dn_lvl, dn_rise, ld_lvl, ld_rise;
  logic active_lvl;

  logic [W-1:0]     sw_s1_q, sw_s2_q;
  ctrl_state_t      state_q;
  logic [RPT_W-1:0] rpt_q;
  logic [1:0]       dir_q;
  logic             en_q;
  logic [1:0]       s_q;
  logic [W-1:0]     d_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk_i(CLK), .rst_i(RST), .btn_i(BTN_UP), .level_o(up_lvl), .rise_o(up_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk_i(CLK), .rst_i(RST), .btn_i(BTN_DN), .level_o(dn_lvl), .rise_o(dn_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
    .clk_i(CLK), .rst_i(RST), .btn_i(BTN_LD), .level_o(ld_lvl), .rise_o(ld_rise)
  );

  // Switches only need synchronizing; they are sampled at the load pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign active_lvl = (dir_q == S_UP) ? up_lvl : dn_lvl;

  // Command FSM; outputs default to NOP so every pulse lasts exactly one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rpt_q   <= '0;
      dir_q   <= S_UP;
      en_q    <= 1'b0;
      s_q     <= S_NOP;
      d_q     <= '0;
    end else begin
      en_q <= 1'b0;
      s_q  <= S_NOP;
      case (state_q)
        IDLE: begin
          if (ld_rise) begin
            en_q    <= 1'b1;
            s_q     <= S_LOAD;
            d_q     <= sw_s2_q;
            state_q <= RELEASE;
          end else if (up_rise) begin
            en_q    <= 1'b1;
            s_q     <= S_UP;
            dir_q   <= S_UP;
            rpt_q   <= RPT_DELAY_LD;
            state_q <= HOLD_WAIT;
          end else if (dn_rise) begin
            en_q    <= 1'b1;
            s_q     <= S_DOWN;
            dir_q   <= S_DOWN;
            rpt_q   <= RPT_DELAY_LD;
            state_q <= HOLD_WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD_WAIT, REPEAT: begin
          if (!active_lvl) begin
            state_q <= RELEASE;
          end else if (rpt_q == '0) begin
            en_q    <= 1'b1;
            s_q     <= dir_q;
            rpt_q   <= RPT_RATE_LD;
            state_q <= REPEAT;
          end else begin
            rpt_q <= rpt_q - RPT_W'(1);
          end
        end
        RELEASE: begin
          if (!(up_lvl || dn_lvl || ld_lvl)) begin
            state_q <= IDLE;
          end else begin
            state_q <= RELEASE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign EN = en_q;
  assign S  = s_q;
  assign D  = d_q;

  counter_cmd_ctrl_sva #(.REPEAT_RATE(REPEAT_RATE)) u_sva (
    .clk_i(CLK), .rst_i(RST), .en_i(en_q), .s_i(s_q)
  );

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl: vector table of button holds plus
// hand sequences for async reset, auto-repeat spacing and reset during repeat.
module tb_counter_cmd_ctrl;

  logic       CLK;
  logic       RST;
  logic       BTN_UP, BTN_DN, BTN_LD;
  logic [3:0] SW;
  logic       EN;
  logic [1:0] S;
  logic [3:0] D;

  int checks   = 0;
  int failures = 0;

  int         p_t[$];
  logic [1:0] p_s[$];
  int         proto_err;
  logic       en_prev;

  typedef struct {
    logic       up;
    logic       dn;
    logic       ld;
    logic [3:0] sw;
    int         hold;
    int         exp_n;
    int         exp_lat;
    logic [1:0] exp_s;
    logic [3:0] exp_d;
  } vec_t;

  vec_t vecs[10];

  counter_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
    .SW(SW), .EN(EN), .S(S), .D(D)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int rel);
    @(posedge CLK);
    #1;
    if (EN !== 1'b1 && S !== 2'b00) proto_err++;
    if (EN === 1'b1 && en_prev === 1'b1) proto_err++;
    en_prev = EN;
    if (EN === 1'b1) begin
      p_t.push_back(rel);
      p_s.push_back(S);
    end
  endtask

  task automatic clear_log();
    p_t.delete();
    p_s.delete();
    proto_err = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int bad_s;
    clear_log();
    BTN_UP = v.up;
    BTN_DN = v.dn;
    BTN_LD = v.ld;
    SW     = v.sw;
    for (int i = 0; i < v.hold + 25; i++) begin
      step(i);
      if (i == v.hold - 1) begin
        BTN_UP = 1'b0;
        BTN_DN = 1'b0;
        BTN_LD = 1'b0;
      end
    end
    check($sformatf("vec%0d_pulses", idx), p_t.size(), v.exp_n);
    if (v.exp_n > 0) begin
      check($sformatf("vec%0d_latency", idx), (p_t.size() > 0) ? p_t[0] : -1, v.exp_lat);
      bad_s = 0;
      foreach (p_s[j]) if (p_s[j] !== v.exp_s) bad_s++;
      check($sformatf("vec%0d_s_code", idx), bad_s, 0);
    end
    check($sformatf("vec%0d_d", idx), int'(D), int'(v.exp_d));
    check($sformatf("vec%0d_protocol", idx), proto_err, 0);
  endtask

  initial begin
    int rep_t[7];
    int bad;

    //          up    dn    ld    sw    hold n  lat s      d
    vecs[0] = '{1'b0, 1'b0, 1'b1, 4'hA, 20, 1, 7, 2'b01, 4'hA};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 4'hA, 3,  0, 0, 2'b00, 4'hA};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 10, 1, 7, 2'b10, 4'hA};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 4'h0, 17, 1, 7, 2'b10, 4'hA};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4'h0, 18, 2, 7, 2'b10, 4'hA};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 4'h0, 26, 3, 7, 2'b11, 4'hA};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'h5, 6,  1, 7, 2'b01, 4'h5};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 4'h9, 4,  1, 7, 2'b11, 4'h5};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 4'h3, 40, 1, 7, 2'b01, 4'h3};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 4'hF, 10, 1, 7, 2'b10, 4'h3};
    rep_t = '{7, 23, 31, 39, 47, 55, 63};

    RST = 1'b1;
    BTN_UP = 1'b0; BTN_DN = 1'b0; BTN_LD = 1'b0; SW = 4'h0;
    en_prev = 1'b0;
    proto_err = 0;
    #23;
    check("reset_en", int'(EN), 0);
    check("reset_s", int'(S), 0);
    check("reset_d", int'(D), 0);
    RST = 1'b0;
    clear_log();
    for (int i = 0; i < 10; i++) step(i);
    check("idle_no_en", p_t.size(), 0);

    foreach (vecs[v]) run_vec(vecs[v], v);

    // Asynchronous reset between clock edges clears the loaded D at once.
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst_en", int'(EN), 0);
    check("async_rst_s", int'(S), 0);
    check("async_rst_d", int'(D), 0);
    #2;
    RST = 1'b0;
    clear_log();
    for (int i = 0; i < 50; i++) step(i);
    check("post_rst_quiet", p_t.size(), 0);

    // Held DOWN: first pulse, repeat delay, then repeat rate until release.
    clear_log();
    BTN_DN = 1'b1;
    for (int i = 0; i < 90; i++) begin
      step(i);
      if (i == 59) BTN_DN = 1'b0;
    end
    check("repeat_count", p_t.size(), 7);
    bad = 0;
    foreach (rep_t[j]) if (j >= p_t.size() || p_t[j] != rep_t[j]) bad++;
    check("repeat_times", bad, 0);
    bad = 0;
    foreach (p_s[j]) if (p_s[j] !== 2'b11) bad++;
    check("repeat_s_code", bad, 0);
    check("repeat_d_kept", int'(D), 0);
    check("repeat_protocol", proto_err, 0);

    // Reset while in REPEAT with UP still held.
    clear_log();
    BTN_UP = 1'b1;
    for (int i = 0; i < 30; i++) step(i);
    check("pre_rst_pulses", p_t.size(), 2);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_en", int'(EN), 0);
    clear_log();
    for (int i = 0; i < 3; i++) step(i);
    check("during_rst_pulses", p_t.size(), 0);
    #2;
    RST = 1'b0;
    clear_log();
    for (int i = 0; i < 20; i++) step(i);
    check("post_rst_first_lat", (p_t.size() > 0) ? p_t[0] : -1, 7);
    check("post_rst_first_s", (p_s.size() > 0) ? int'(p_s[0]) : -1, 2);
    check("post_rst_count", p_t.size(), 1);
    BTN_UP = 1'b0;
    for (int i = 20; i < 40; i++) step(i);
    check("post_rst_protocol", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_cmd_ctrl.md
Name: counter_cmd_ctrl

Overview:
Front-end command stage for the 4-bit up/down/load counter. Takes raw pushbuttons (up, down, load) and data switches, then synchronizes and debounces them. Drives the counter's EN / S / D inputs with clean single-cycle commands, including auto-repeat while UP or DOWN is held. Sits between board I/O pins and the counter; its outputs connect directly to the counter's EN, S, D.

Parameters:
W, 4, data/switch width (matches counter D width)
DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (board builds override, e.g. 500000)
REPEAT_DELAY, 16, cycles of continued hold after first pulse before auto-repeat starts
REPEAT_RATE, 8, cycles between auto-repeat pulses

Ports:
CLK  input  1  system clock
RST  input  1  reset; asynchronous, active-high
BTN_UP  input  1  raw count-up button, active-high, asynchronous to CLK
BTN_DN  input  1  raw count-down button, active-high, asynchronous to CLK
BTN_LD  input  1  raw load button, active-high, asynchronous to CLK
SW  input  W  raw data switches, asynchronous to CLK
EN  output  1  one-cycle command strobe to counter
S  output  2  function select: 01 load, 10 up, 11 down; 00 whenever EN=0
D  output  W  load data; valid when EN=1 with S=01, otherwise holds last value

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high. All state is cleared immediately on RST rising, independent of CLK.
- Reset values: EN=0, S=00, D=0. FSM in IDLE. All synchronizer, debounce and repeat counters are 0. Debounced levels are 0.
- Synchronization: each button and each SW bit passes through a 2-flop synchronizer.
- Debounce (per button):
  - Counter increments while the synchronized level differs from the debounced level; it resets to 0 when they match.
  - When the counter reaches DB_CYCLES-1, the debounced level toggles and the counter clears.
  - A pulse shorter than DB_CYCLES synchronized cycles produces no level change.
- Edge detect: a one-cycle "press" flag fires on each debounced 0->1 transition.
- Latency: with a button held steady high, EN rises on clock edge k+DB_CYCLES+3, where k is the first edge at which the synchronizer's first flop samples 1. Default latency is 7 edges. All outputs are registered.
- FSM states: IDLE, HOLD_WAIT, REPEAT, RELEASE.
  - IDLE: on a press flag, issue one command pulse (EN=1 for exactly one cycle with the matching S).
    - Priority when press flags coincide: LD > UP > DN.
    - LD: D latches the synchronized SW in the same cycle; next state RELEASE.
    - UP/DN: load the repeat counter with REPEAT_DELAY-1; next state HOLD_WAIT. The active direction is recorded.
  - HOLD_WAIT: decrement the repeat counter.
    - If the active button's debounced level drops, go to RELEASE.
    - At 0, issue one pulse in the recorded direction, reload REPEAT_RATE-1, go to REPEAT.
  - REPEAT: same as HOLD_WAIT, but reloads REPEAT_RATE-1 after each pulse and stays in REPEAT.
  - RELEASE: wait until all three debounced levels are 0, then go to IDLE. No commands are issued.
- Conflicting input: presses of other buttons while not in IDLE are ignored. No queuing; they are lost.
- Pulse spacing: EN is never high in two consecutive cycles. REPEAT_RATE >= 2 is required; a simulation assertion enforces it.
- D: changes only on load pulses. UP/DN pulses leave D unchanged.
- Reset mid-operation: any pending or in-flight pulse is dropped. After release, a button still held must first debounce from 0 before it is treated as a new press.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state enum ctrl_state_t {IDLE, HOLD_WAIT, REPEAT, RELEASE}
  - S-code constants: S_NOP=2'b00, S_LOAD=2'b01, S_UP=2'b10, S_DOWN=2'b11
- One sub-module, btn_debounce (parameter DB_CYCLES), containing the 2-flop synchronizer, debounce counter, debounced level output and rise-pulse output. It is instantiated 3 times.
- The SW synchronizer and the FSM stay in the top module.

Test Plan:
1. RST pulse mid-cycle (asynchronous) with all buttons low -> EN=0, S=00, D=0 immediately. No EN over the next 50 cycles.
2. BTN_UP high 3 cycles then low (glitch, DB_CYCLES=4) -> no EN at any time.
3. SW=4'hA, BTN_LD held 20 cycles -> exactly one EN with S=01, D=4'hA, 7 edges after first sample. D stays 4'hA afterwards.
4. BTN_DN held 60 cycles -> pulses (S=11) at t0, t0+16, t0+24, t0+32, … After release, no further pulses; FSM returns to IDLE.
5. BTN_UP and BTN_LD rise in the same cycle -> single load pulse (S=01). No up pulse, even while UP remains held, until all buttons are released and re-pressed.
6. BTN_UP held; RST asserted during REPEAT and released while UP is still held -> no EN during or after reset until the debounced level rises again. First post-reset pulse arrives at the normal latency.
